// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, signed or unsigned
// per request, with quotient/remainder held until the next completion.
module divisor_secuencial #(
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         signed_op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div_zero_o,
    output logic [N-1:0] q_o,
    output logic [N-1:0] r_o
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    a_raw_q, a_raw_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    r_q, r_d;

    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    logic [N:0]   shifted, trial;

    always_comb begin
        a_neg   = signed_op_i & a_i[N-1];
        b_neg   = signed_op_i & b_i[N-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;
        // Remainder stays below the divisor, so N bits of it plus the next dividend bit suffice.
        shifted = {rem_q, dvd_q[N-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        q_d       = q_q;
        r_d       = r_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_raw_d   = a_i;
                    dvd_d     = a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    rem_d     = '0;
                    cnt_d     = CntW'(N);
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (!trial[N]) begin
                    rem_d = trial[N-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b1};
                end else begin
                    rem_d = shifted[N-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                done_d  = 1'b1;
                state_d = StIdle;
                // A zero magnitude only arises from a zero divisor.
                if (dvs_q == '0) begin
                    q_d  = '1;
                    r_d  = a_raw_q;
                    dz_d = 1'b1;
                end else begin
                    q_d  = neg_quo_q ? -dvd_q : dvd_q;
                    r_d  = neg_rem_q ? -rem_q : rem_q;
                    dz_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            q_q       <= q_d;
            r_q       <= r_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign q_o        = q_q;
    assign r_o        = r_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: latency, signed/unsigned quadrants, divide by zero,
// handshake corner cases and asynchronous reset during a division.
module tb_divisor_secuencial;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         start;
    logic         signed_op;
    logic [N-1:0] a_in, b_in;
    logic         busy_o, done_o, div_zero_o;
    logic [N-1:0] q_o, r_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divisor_secuencial #(.N(N)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .signed_op_i(signed_op),
        .a_i        (a_in),
        .b_i        (b_in),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .q_o        (q_o),
        .r_o        (r_o)
    );

    typedef struct {
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
    } vec_t;

    // Called 1 time unit after the accepting edge; lat counts edges until DONE is seen (0 = none).
    task automatic wait_done(output int lat, output int bcnt);
        bcnt = busy_o ? 1 : 0;
        lat  = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
            if (busy_o) bcnt++;
        end
    endtask

    task automatic run_div(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output int bcnt);
        @(negedge clk);
        signed_op = s;
        a_in      = a;
        b_in      = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    task automatic test_reset;
        #1;
        n_vec += 5;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
        if (div_zero_o !== 1'b0) begin
            n_err++; $display("FAIL reset_dz: got %b want 0", div_zero_o);
        end
        if (q_o !== '0) begin n_err++; $display("FAIL reset_q: got %h want 0", q_o); end
        if (r_o !== '0) begin n_err++; $display("FAIL reset_r: got %h want 0", r_o); end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat, bcnt;
        run_div(1'b0, 32'd100, 32'd7, lat, bcnt);
        n_vec += 5;
        if (lat !== 33) begin n_err++; $display("FAIL u_latency: got %0d want 33", lat); end
        if (bcnt !== 33) begin n_err++; $display("FAIL u_busy_cycles: got %0d want 33", bcnt); end
        if (q_o !== 32'd14) begin n_err++; $display("FAIL u_q: got %h want %h", q_o, 32'd14); end
        if (r_o !== 32'd2) begin n_err++; $display("FAIL u_r: got %h want %h", r_o, 32'd2); end
        if (div_zero_o !== 1'b0) begin n_err++; $display("FAIL u_dz: got %b want 0", div_zero_o); end
        @(posedge clk);
        #1;
        n_vec += 2;
        if (done_o !== 1'b0) begin n_err++; $display("FAIL u_done_pulse: got %b want 0", done_o); end
        if (q_o !== 32'd14) begin n_err++; $display("FAIL u_q_hold: got %h want %h", q_o, 32'd14); end
    endtask

    task automatic test_signed_modes;
        vec_t tbl [10];
        int   lat, bcnt;
        tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        tbl[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        tbl[2] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        tbl[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
        tbl[5] = '{1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1};
        tbl[6] = '{1'b1, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF};
        tbl[7] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        tbl[8] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        tbl[9] = '{1'b1, 32'd0,        32'd5,        32'd0,        32'd0};
        for (int i = 0; i < 10; i++) begin
            run_div(tbl[i].s, tbl[i].a, tbl[i].b, lat, bcnt);
            n_vec += 4;
            if (lat !== 33) begin n_err++; $display("FAIL sm%0d_latency: got %0d want 33", i, lat); end
            if (q_o !== tbl[i].q) begin
                n_err++; $display("FAIL sm%0d_q: got %h want %h", i, q_o, tbl[i].q);
            end
            if (r_o !== tbl[i].r) begin
                n_err++; $display("FAIL sm%0d_r: got %h want %h", i, r_o, tbl[i].r);
            end
            if (div_zero_o !== 1'b0) begin
                n_err++; $display("FAIL sm%0d_dz: got %b want 0", i, div_zero_o);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_div(1'b1, 32'd5, 32'd0, lat, bcnt);
        n_vec += 4;
        if (lat !== 33) begin n_err++; $display("FAIL dz_latency: got %0d want 33", lat); end
        if (q_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_q: got %h want ffffffff", q_o); end
        if (r_o !== 32'd5) begin n_err++; $display("FAIL dz_r: got %h want 5", r_o); end
        if (div_zero_o !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", div_zero_o); end
        run_div(1'b1, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        n_vec += 2;
        if (r_o !== 32'hFFFFFFF9) begin
            n_err++; $display("FAIL dz_neg_r: got %h want fffffff9", r_o);
        end
        if (div_zero_o !== 1'b1) begin n_err++; $display("FAIL dz_neg_flag: got %b want 1", div_zero_o); end
        run_div(1'b0, 32'd9, 32'd3, lat, bcnt);
        n_vec += 3;
        if (q_o !== 32'd3) begin n_err++; $display("FAIL dz_next_q: got %h want 3", q_o); end
        if (r_o !== 32'd0) begin n_err++; $display("FAIL dz_next_r: got %h want 0", r_o); end
        if (div_zero_o !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b want 0", div_zero_o); end
    endtask

    task automatic test_start_while_busy;
        int lat, bcnt;
        @(negedge clk);
        signed_op = 1'b0;
        a_in      = 32'd100;
        b_in      = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        signed_op = 1'b1;
        a_in      = 32'd1000;
        b_in      = 32'hFFFFFFFD;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        n_vec += 3;
        if (lat + 10 !== 33 || lat == 0) begin
            n_err++; $display("FAIL swb_latency: got %0d want 33", lat + 10);
        end
        if (q_o !== 32'd14) begin n_err++; $display("FAIL swb_q: got %h want %h", q_o, 32'd14); end
        if (r_o !== 32'd2) begin n_err++; $display("FAIL swb_r: got %h want %h", r_o, 32'd2); end
        repeat (2) @(posedge clk);
        #1;
        n_vec += 1;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL swb_no_queue: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_div(1'b0, 32'd100, 32'd7, lat, bcnt);
        signed_op = 1'b1;
        a_in      = 32'hFFFFFFF9;
        b_in      = 32'd2;
        start     = 1'b1;
        n_vec += 1;
        if (done_o !== 1'b1) begin n_err++; $display("FAIL b2b_done_cycle: got %b want 1", done_o); end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec += 3;
        if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy_o); end
        if (done_o !== 1'b0) begin n_err++; $display("FAIL b2b_done_low: got %b want 0", done_o); end
        if (q_o !== 32'd14) begin n_err++; $display("FAIL b2b_q_hold: got %h want %h", q_o, 32'd14); end
        wait_done(lat, bcnt);
        n_vec += 3;
        if (lat !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        if (q_o !== 32'hFFFFFFFD) begin n_err++; $display("FAIL b2b_q: got %h want fffffffd", q_o); end
        if (r_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_r: got %h want ffffffff", r_o); end
    endtask

    task automatic test_reset_midop;
        int lat, bcnt;
        int seen_done;
        @(negedge clk);
        signed_op = 1'b0;
        a_in      = 32'd100;
        b_in      = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec += 4;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL rmo_busy: got %b want 0", busy_o); end
        if (q_o !== '0) begin n_err++; $display("FAIL rmo_q: got %h want 0", q_o); end
        if (r_o !== '0) begin n_err++; $display("FAIL rmo_r: got %h want 0", r_o); end
        if (div_zero_o !== 1'b0) begin n_err++; $display("FAIL rmo_dz: got %b want 0", div_zero_o); end
        @(negedge clk);
        rst_ni    = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o) seen_done++;
        end
        n_vec += 1;
        if (seen_done !== 0) begin n_err++; $display("FAIL rmo_no_done: got %0d want 0", seen_done); end
        run_div(1'b0, 32'd100, 32'd7, lat, bcnt);
        n_vec += 3;
        if (lat !== 33) begin n_err++; $display("FAIL rmo_latency: got %0d want 33", lat); end
        if (q_o !== 32'd14) begin n_err++; $display("FAIL rmo_q_after: got %h want %h", q_o, 32'd14); end
        if (r_o !== 32'd2) begin n_err++; $display("FAIL rmo_r_after: got %h want %h", r_o, 32'd2); end
    endtask

    initial begin
        rst_ni    = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #2;
        rst_ni = 1'b0;
        test_reset();
        test_unsigned();
        test_signed_modes();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
